// File: rtl/mem_rmw_pkg.sv
// mem_rmw_pkg: shared size/state encodings and the alignment rule for mem_rmw_unit
package mem_rmw_pkg;
    localparam int WORD_W = 32;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL} size_e;
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;
    function automatic logic is_misaligned(size_e sz, logic [1:0] lane);
        return sz == SZ_ILLEGAL || (sz == SZ_HALF && lane[0]) || (sz == SZ_WORD && lane != 2'b00);
    endfunction
endpackage

// File: rtl/mem_lane_merge.sv
// mem_lane_merge: little-endian lane extract/extend for loads and lane merge for stores
module mem_lane_merge
    import mem_rmw_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  size_e             size,
    input  logic [1:0]        lane,
    input  logic              is_unsigned,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merged
);
    logic [4:0]        sh;
    logic [7:0]        b;
    logic [15:0]       h;
    logic [WORD_W-1:0] mask;
    always_comb begin
        sh        = size == SZ_HALF ? {lane[1], 4'b0} : {lane, 3'b0};
        b         = 8'(word >> sh);
        h         = 16'(word >> sh);
        load_data = size == SZ_BYTE ? {{24{b[7] & ~is_unsigned}}, b} :
                    size == SZ_HALF ? {{16{h[15] & ~is_unsigned}}, h} : word;
        mask      = size == SZ_BYTE ? 32'hFF << sh : size == SZ_HALF ? 32'hFFFF << sh : '1;
        merged    = (word & ~mask) | ((wdata << sh) & mask);
    end
endmodule

// File: rtl/mem_rmw_unit.sv
// mem_rmw_unit: byte/half/word load-store unit doing read-modify-write on a word memory.
// MEM_RMW_WORD_BYPASS_EN: aligned word stores skip the read and go straight to WRITE.
module mem_rmw_unit
    import mem_rmw_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_misaligned,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [DATA_W-1:0] mem_write_data
);
    state_e            state;
    size_e             size_q;
    logic [1:0]        lane_q;
    logic              write_q;
    logic              uns_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] word_addr;
    logic              we_q;
    logic              bypass;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged;

    assign req_ready         = state == IDLE;
    assign mem_read_address  = word_addr;
    assign mem_write_address = word_addr;
    // Gated so a reset landing on a WRITE cycle can never commit the word.
    assign mem_write_enable  = we_q & ~RESET;

`ifdef MEM_RMW_WORD_BYPASS_EN
    assign bypass = req_write && size_e'(req_size) == SZ_WORD;
`else
    assign bypass = 1'b0;
`endif

    mem_lane_merge u_lane (
        .word        (mem_read_data),
        .size        (size_q),
        .lane        (lane_q),
        .is_unsigned (uns_q),
        .wdata       (data_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state           <= IDLE;
            size_q          <= SZ_BYTE;
            lane_q          <= '0;
            write_q         <= 1'b0;
            uns_q           <= 1'b0;
            data_q          <= '0;
            word_addr       <= '0;
            we_q            <= 1'b0;
            resp_valid      <= 1'b0;
            resp_misaligned <= 1'b0;
            resp_data       <= '0;
            mem_write_data  <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    size_q    <= size_e'(req_size);
                    lane_q    <= req_address[1:0];
                    write_q   <= req_write;
                    uns_q     <= req_unsigned;
                    data_q    <= req_data;
                    word_addr <= {req_address[ADDR_W-1:2], 2'b00};
                    if (is_misaligned(size_e'(req_size), req_address[1:0])) begin
                        state           <= RESP;
                        resp_valid      <= 1'b1;
                        resp_misaligned <= 1'b1;
                        resp_data       <= '0;
                    end else if (bypass) begin
                        state          <= WRITE;
                        mem_write_data <= req_data;
                        we_q           <= 1'b1;
                    end else begin
                        state <= READ;
                    end
                end
                READ: if (write_q) begin
                    state          <= WRITE;
                    mem_write_data <= merged;
                    we_q           <= 1'b1;
                end else begin
                    state           <= RESP;
                    resp_valid      <= 1'b1;
                    resp_misaligned <= 1'b0;
                    resp_data       <= load_data;
                end
                WRITE: begin
                    state           <= RESP;
                    we_q            <= 1'b0;
                    resp_valid      <= 1'b1;
                    resp_misaligned <= 1'b0;
                    resp_data       <= '0;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_rmw_unit.sv
// tb_mem_rmw_unit: directed vectors against a byte-addressed reference memory model
module tb_mem_rmw_unit;
`ifdef MEM_RMW_WORD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        CLK = 1'b0, RESET = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_address = '0, req_data = '0;
    logic        req_ready, resp_valid, resp_misaligned, mem_write_enable;
    logic [31:0] resp_data, mem_read_address, mem_read_data, mem_write_address, mem_write_data;

    typedef struct {int cyc; logic [31:0] d; logic m;} resp_t;
    typedef struct {int cyc; logic [31:0] a; logic [31:0] d;} wr_t;
    resp_t       exp_resp[$];
    wr_t         exp_wr[$];
    logic [7:0]  mb[0:63];
    logic [31:0] dmem[0:15];
    int          cyc = 0, nvec = 0, nfail = 0, obs_cnt = 0, obs_cyc = 0;
    logic [31:0] obs_data = '0;
    logic        obs_mis = 1'b0, er, ew;

    mem_rmw_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
        .req_data(req_data), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_misaligned(resp_misaligned), .mem_read_address(mem_read_address),
        .mem_read_data(mem_read_data), .mem_write_enable(mem_write_enable),
        .mem_write_address(mem_write_address), .mem_write_data(mem_write_data)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    assign mem_read_data = dmem[mem_read_address[5:2]];
    always @(posedge CLK) if (mem_write_enable) dmem[mem_write_address[5:2]] <= mem_write_data;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    function automatic int bi(input logic [31:0] a, input int k);
        return (int'(a[5:0]) + k) & 63;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {mb[bi(a, 3)], mb[bi(a, 2)], mb[bi(a, 1)], mb[bi(a, 0)]};
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
        logic [31:0] v;
        int n;
        v = '0;
        n = 1 << sz;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mb[bi(a, k)];
        if (!u && n < 4 && v[8*n-1])
            for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    // One compare process: every cycle the response pulse and write strobe must match the model.
    always @(negedge CLK) begin
        if (RESET) begin
            chk("we_in_reset", 32'(mem_write_enable), 32'd0);
        end else begin
            er = exp_resp.size() > 0 && exp_resp[0].cyc == cyc;
            ew = exp_wr.size() > 0 && exp_wr[0].cyc == cyc;
            chk("resp_valid", 32'(resp_valid), 32'(er));
            chk("mem_write_enable", 32'(mem_write_enable), 32'(ew));
            if (resp_valid) begin
                obs_cnt++;
                obs_cyc  = cyc;
                obs_data = resp_data;
                obs_mis  = resp_misaligned;
            end
            if (er) begin
                if (!exp_resp[0].m) chk("resp_data", resp_data, exp_resp[0].d);
                chk("resp_misaligned", 32'(resp_misaligned), 32'(exp_resp[0].m));
                void'(exp_resp.pop_front());
            end
            if (ew) begin
                chk("mem_write_address", mem_write_address, exp_wr[0].a);
                chk("mem_write_data", mem_write_data, exp_wr[0].d);
                void'(exp_wr.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge CLK);
        while (!req_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] ad, input logic [31:0] dt, input bit noisy,
                          input bit lit, input logic [31:0] lit_d, input logic lit_m, input int lit_lat);
        int a, lat, c0, n;
        logic mis;
        resp_t r;
        wr_t wr;
        wait_ready();
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_address = ad; req_data = dt;
        a = cyc;
        c0 = obs_cnt;
        mis = sz == 2'd3 || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'd0);
        lat = mis ? 1 : !w ? 2 : (BYP && sz == 2'd2) ? 2 : 3;
        r.cyc = a + lat; r.d = '0; r.m = mis;
        if (!mis && !w) r.d = m_load(ad, sz, u);
        if (!mis && w) begin
            for (int k = 0; k < (1 << sz); k++) mb[bi(ad, k)] = dt[8*k +: 8];
            wr.cyc = a + lat - 1;
            wr.a = {ad[31:2], 2'b00};
            wr.d = word_of(wr.a);
            exp_wr.push_back(wr);
        end
        exp_resp.push_back(r);
        @(posedge CLK); #1;
        if (noisy) begin
            req_address = ad ^ 32'h4; req_data = ~dt; req_write = ~w; req_size = 2'd0;
            repeat (lat - 1) @(posedge CLK);
            #1;
        end
        req_valid = 1'b0;
        n = 0;
        while (obs_cnt == c0 && n < 10) begin
            @(negedge CLK); #1;
            n++;
        end
        chk("resp_seen", 32'(obs_cnt - c0), 32'd1);
        if (lit) begin
            chk("lit_latency", 32'(obs_cyc - a), 32'(lit_lat));
            chk("lit_misaligned", 32'(obs_mis), 32'(lit_m));
            if (!lit_m) chk("lit_data", obs_data, lit_d);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mb[i] = 8'(i * 37 + 11);
        mb[16] = 8'hDD; mb[17] = 8'hCC; mb[18] = 8'hBB; mb[19] = 8'hAA;
        for (int i = 0; i < 64; i++) dmem[i / 4][8*(i % 4) +: 8] = mb[i];
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_read_addr", mem_read_address, 32'd0);
        chk("rst_write_addr", mem_write_address, 32'd0);
        chk("rst_write_data", mem_write_data, 32'd0);

        do_req(0, 2'd0, 0, 32'h8000_0011, 0, 0, 1, 32'hFFFF_FFCC, 0, 2);
        do_req(0, 2'd1, 1, 32'h8000_0012, 0, 0, 1, 32'h0000_AABB, 0, 2);
        do_req(1, 2'd0, 0, 32'h8000_0012, 32'h0000_005A, 1, 1, 32'h0, 0, 3);
        chk("mem_after_byte_store", dmem[4], 32'hAA5A_CCDD);
        do_req(0, 2'd1, 0, 32'h8000_0013, 0, 0, 1, 32'h0, 1, 1);

        // Reset lands while a byte store sits in READ: nothing may be written or answered.
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_address = 32'h8000_0010; req_data = 32'h0000_00EE;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        repeat (4) @(negedge CLK);
        chk("mem_after_abort", dmem[4], 32'hAA5A_CCDD);

        do_req(1, 2'd2, 0, 32'h8000_0010, 32'h1122_3344, 0, 1, 32'h0, 0, BYP ? 2 : 3);
        chk("mem_after_word_store", dmem[4], 32'h1122_3344);
        do_req(0, 2'd1, 0, 32'h8000_0012, 0, 0, 1, 32'h0000_1122, 0, 2);
        do_req(0, 2'd0, 0, 32'h8000_0014, 0, 0, 1, 32'hFFFF_FFEF, 0, 2);
        do_req(0, 2'd2, 0, 32'h8000_0010, 0, 0, 1, 32'h1122_3344, 0, 2);
        do_req(0, 2'd3, 0, 32'h8000_0010, 0, 0, 1, 32'h0, 1, 1);
        do_req(1, 2'd2, 0, 32'h8000_0012, 32'hCAFE_F00D, 0, 1, 32'h0, 1, 1);
        do_req(1, 2'd1, 0, 32'h8000_0016, 32'h1234_BEEF, 1, 1, 32'h0, 0, 3);
        chk("mem_after_half_store", dmem[5], 32'hBEEF_14EF);
        do_req(0, 2'd0, 1, 32'h8000_0017, 0, 0, 1, 32'h0000_00BE, 0, 2);
        do_req(0, 2'd1, 0, 32'h8000_0016, 0, 0, 1, 32'hFFFF_BEEF, 0, 2);
        do_req(1, 2'd0, 1, 32'h8000_0003, 32'hFFFF_FF77, 0, 0, 32'h0, 0, 0);
        do_req(0, 2'd2, 0, 32'h8000_0000, 0, 0, 0, 32'h0, 0, 0);

        repeat (3) @(negedge CLK);
        chk("resp_queue_drained", 32'(exp_resp.size()), 32'd0);
        chk("write_queue_drained", 32'(exp_wr.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
